// File: rtl/seq_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock.
// Define DIVZ_SHORTCUT_EN to finish a divide by zero in one cycle.
module sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        Cout
);
  // Cout=1 means no borrow, i.e. a >= b
  assign {Cout, sum} = {1'b0, a} + {1'b0, ~b} + 33'd1;
endmodule

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] rem;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dq_nx;

  assign partial = {rem[WIDTH-2:0], dq[WIDTH-1]};

  sub u_sub (
    .a    (partial),
    .b    (divr),
    .sum  (diff),
    .Cout (cout)
  );

  // rem[31] set: shifted value is >= 2^32, always exceeds divisor
  assign take   = rem[WIDTH-1] | cout;
  assign rem_nx = take ? diff : partial;
  assign dq_nx  = {dq[WIDTH-2:0], take};

`ifdef DIVZ_SHORTCUT_EN
  logic dbz;
  assign div_by_zero = dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      divr      <= '0;
      dq        <= '0;
      rem       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVZ_SHORTCUT_EN
      dbz       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIVZ_SHORTCUT_EN
      dbz  <= 1'b0;
`endif
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            divr <= divisor;
            dq   <= dividend;
            rem  <= '0;
            cnt  <= '0;
`ifdef DIVZ_SHORTCUT_EN
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              dbz       <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dq_nx;
            remainder <= rem_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Expectations follow DIVZ_SHORTCUT_EN when it is defined.
module tb_seq_divider;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int compared;
  int mismatched;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      compared++;
      if (busy && done) begin
        mismatched++;
        $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1",
                 busy, done);
      end
    end
  end

  // Drive start for one edge (E0); returns #1 after E0
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen, bounded
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_div(input string nm, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic dz);
    int n;
    pulse_start(a, b);
    wait_done(n);
    compared++;
    if (n !== lat) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d edges, required %0d", nm, n, lat);
    end
    compared++;
    if (quotient !== q) begin
      mismatched++;
      $display("FAIL %s_quotient: got %h, required %h", nm, quotient, q);
    end
    compared++;
    if (remainder !== r) begin
      mismatched++;
      $display("FAIL %s_remainder: got %h, required %h", nm, remainder, r);
    end
    compared++;
    if (div_by_zero !== dz) begin
      mismatched++;
      $display("FAIL %s_dbz: got %b, required %b", nm, div_by_zero, dz);
    end
    @(posedge clk);
    #1;
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_after: done=%b busy=%b, required 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 0 ||
        remainder !== 0) begin
      mismatched++;
      $display("FAIL reset_state: b=%b d=%b z=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_div("d100_7", 32'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0);
    run_div("ff_8000", 32'hFFFFFFFF, 32'h80000000, 32, 32'd1,
            32'h7FFFFFFF, 1'b0);
    run_div("ff_1", 32'hFFFFFFFF, 32'd1, 32, 32'hFFFFFFFF, 32'd0, 1'b0);
  endtask

  task automatic test_div_zero();
`ifdef DIVZ_SHORTCUT_EN
    run_div("d5_0", 32'd5, 32'd0, 0, 32'hFFFFFFFF, 32'd5, 1'b1);
`else
    run_div("d5_0", 32'd5, 32'd0, 32, 32'hFFFFFFFF, 32'd5, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_start(32'd9, 32'd3);
    wait_done(n);
    compared++;
    if (n !== 32 || quotient !== 32'd3 || remainder !== 32'd0) begin
      mismatched++;
      $display("FAIL b2b_first: n=%0d q=%0d r=%0d, required 32 3 0",
               n, quotient, remainder);
    end
    pulse_start(32'd10, 32'd4);
    compared++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy, done);
    end
    n = 0;
    repeat (5) begin
      @(posedge clk);
      n++;
    end
    #1;
    pulse_start(32'd1000, 32'd1);
    n++;
    pulse_start(32'd77, 32'd5);
    n++;
    compared++;
    if (quotient !== 32'd3 || remainder !== 32'd0) begin
      mismatched++;
      $display("FAIL b2b_hold: q=%0d r=%0d, required 3 0", quotient, remainder);
    end
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (n !== 32 || quotient !== 32'd2 || remainder !== 32'd2) begin
      mismatched++;
      $display("FAIL b2b_second: n=%0d q=%0d r=%0d, required 32 2 2",
               n, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    pulse_start(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 0 ||
        remainder !== 0) begin
      mismatched++;
      $display("FAIL abort_state: b=%b d=%b z=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: busy=%b, required 0", busy);
    end
    run_div("d1000_3", 32'd1000, 32'd3, 32, 32'd333, 32'd1, 1'b0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
